// File: rtl/softmax_pkg.sv
// Shared constants and types for the softmax AXI4-Stream transmit path.
package softmax_pkg;

  localparam int DATA_SIZE = 16;
  localparam int VEC_CNT_W = 8;
  localparam int FIFO_DEPTH = 4;
  localparam logic [DATA_SIZE-1:0] PAD_VALUE = 16'h8000;

  // LO: no element held; HI: low half of the next beat is held.
  typedef enum logic {
    PK_LO = 1'b0,
    PK_HI = 1'b1
  } pack_state_e;

endpackage

// File: rtl/axis_beat_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible
// combinationally whenever the FIFO is not empty.
module axis_beat_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             axi_clock_i,
  input  logic             axi_reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign head_data_o = mem_q[rd_ptr_q];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge axi_clock_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge axi_clock_i) begin
    if (!axi_reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/softmax_axis_packer_16.sv
// Packs a stream of single elements into two-element AXI4-Stream beats for the
// softmax input, padding odd-length vectors and reporting the vector length.
module softmax_axis_packer_16
  import softmax_pkg::*;
#(
  parameter int                    data_size  = DATA_SIZE,
  parameter int                    fifo_depth = FIFO_DEPTH,
  parameter logic [data_size-1:0]  pad_value  = PAD_VALUE
) (
  input  logic                   axi_clock_i,
  input  logic                   axi_reset_n_i,
  input  logic                   elem_valid_i,
  input  logic [data_size-1:0]   elem_data_i,
  input  logic                   elem_last_i,
  output logic                   elem_ready_o,
  input  logic                   m_axis_ready_i,
  output logic [2*data_size-1:0] m_axis_data_o,
  output logic                   m_axis_valid_o,
  output logic                   m_axis_last_o,
  output logic [VEC_CNT_W-1:0]   pack_vec_len_o,
  output logic                   pack_vec_done_o,
  output logic                   pack_overflow_o
);

  localparam int BEAT_W = 2 * data_size;

  pack_state_e            state_q;
  logic [data_size-1:0]   low_q;
  logic [VEC_CNT_W-1:0]   cnt_q;
  logic [VEC_CNT_W-1:0]   cnt_d;
  logic [VEC_CNT_W-1:0]   len_q;
  logic                   done_q;
  logic                   ovf_q;

  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [BEAT_W:0]        push_word;
  logic [BEAT_W:0]        head_word;

  assign elem_ready_o = !fifo_full;
  assign accept       = elem_valid_i && elem_ready_o;
  assign push         = accept && ((state_q == PK_HI) || elem_last_i);
  // In LO a beat is only pushed for a last element, so the pad fills the top lane.
  assign push_word    = (state_q == PK_HI) ? {elem_last_i, elem_data_i, low_q}
                                           : {elem_last_i, pad_value, elem_data_i};

  assign m_axis_valid_o = !fifo_empty;
  assign pop            = m_axis_valid_o && m_axis_ready_i;
  assign {m_axis_last_o, m_axis_data_o} = fifo_empty ? '0 : head_word;

  assign pack_vec_len_o  = len_q;
  assign pack_vec_done_o = done_q;
  assign pack_overflow_o = ovf_q;

  // Saturating element count including the element being accepted.
  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + VEC_CNT_W'(1);

  axis_beat_fifo #(
    .WIDTH (BEAT_W + 1),
    .DEPTH (fifo_depth)
  ) u_beat_fifo (
    .axi_clock_i   (axi_clock_i),
    .axi_reset_n_i (axi_reset_n_i),
    .push_i        (push),
    .push_data_i   (push_word),
    .pop_i         (pop),
    .head_data_o   (head_word),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  always_ff @(posedge axi_clock_i) begin
    if (!axi_reset_n_i) begin
      state_q <= PK_LO;
      low_q   <= '0;
    end else if (accept) begin
      case (state_q)
        PK_LO: begin
          if (!elem_last_i) begin
            low_q   <= elem_data_i;
            state_q <= PK_HI;
          end
        end
        PK_HI:   state_q <= PK_LO;
        default: state_q <= PK_LO;
      endcase
    end
  end

  always_ff @(posedge axi_clock_i) begin
    if (!axi_reset_n_i) begin
      cnt_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (cnt_q == '1) begin
          ovf_q <= 1'b1;
        end
        if (elem_last_i) begin
          len_q  <= cnt_d;
          done_q <= 1'b1;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_softmax_axis_packer_16.sv
// Randomized bench for softmax_axis_packer_16 against a vector-level model.
module tb_softmax_axis_packer_16;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] PAD = 16'h8000;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } elem_t;

  logic          axi_clock_i = 1'b0;
  logic          axi_reset_n_i;
  logic          elem_valid_i;
  logic [DW-1:0] elem_data_i;
  logic          elem_last_i;
  logic          elem_ready_o;
  logic          m_axis_ready_i;
  logic [2*DW-1:0] m_axis_data_o;
  logic          m_axis_valid_o;
  logic          m_axis_last_o;
  logic [7:0]    pack_vec_len_o;
  logic          pack_vec_done_o;
  logic          pack_overflow_o;

  softmax_axis_packer_16 dut (
    .axi_clock_i     (axi_clock_i),
    .axi_reset_n_i   (axi_reset_n_i),
    .elem_valid_i    (elem_valid_i),
    .elem_data_i     (elem_data_i),
    .elem_last_i     (elem_last_i),
    .elem_ready_o    (elem_ready_o),
    .m_axis_ready_i  (m_axis_ready_i),
    .m_axis_data_o   (m_axis_data_o),
    .m_axis_valid_o  (m_axis_valid_o),
    .m_axis_last_o   (m_axis_last_o),
    .pack_vec_len_o  (pack_vec_len_o),
    .pack_vec_done_o (pack_vec_done_o),
    .pack_overflow_o (pack_overflow_o)
  );

  always #5 axi_clock_i = ~axi_clock_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;

  // Model state: pending stimulus, beats owed downstream, vector bookkeeping.
  elem_t         stim[$];
  logic [2*DW:0] exp_q[$];
  logic [DW-1:0] pend[$];
  int            vec_cnt;
  logic [7:0]    exp_len;
  logic          exp_done;
  logic          exp_ovf;
  int            m_mode;   // 0: never ready, 1: always ready, 2: random
  bit            v_rand;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    stim.delete();
    exp_q.delete();
    pend.delete();
    vec_cnt  = 0;
    exp_len  = '0;
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    logic [DW-1:0] hi;
    if (vec_cnt >= 255) exp_ovf = 1'b1;
    vec_cnt++;
    pend.push_back(d);
    if (pend.size() == 2 || l) begin
      hi = (pend.size() == 2) ? pend[1] : PAD;
      exp_q.push_back({l, hi, pend[0]});
      pend.delete();
    end
    if (l) begin
      exp_len  = (vec_cnt > 255) ? 8'd255 : 8'(vec_cnt);
      exp_done = 1'b1;
      vec_cnt  = 0;
    end
  endtask

  task automatic check_outputs();
    logic [2*DW:0] head;
    check_eq("m_valid", 64'(m_axis_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_eq("m_data", 64'(m_axis_data_o), 64'(head[2*DW-1:0]));
      check_eq("m_last", 64'(m_axis_last_o), 64'(head[2*DW]));
    end
    check_eq("elem_ready", 64'(elem_ready_o), 64'(exp_q.size() < DEPTH));
    check_eq("vec_done", 64'(pack_vec_done_o), 64'(exp_done));
    check_eq("vec_len", 64'(pack_vec_len_o), 64'(exp_len));
    check_eq("overflow", 64'(pack_overflow_o), 64'(exp_ovf));
    exp_done = 1'b0;
  endtask

  task automatic drive();
    bit acc;
    bit pop;
    logic [2*DW:0] b;
    elem_t e;
    elem_valid_i = 1'b0;
    elem_data_i  = '0;
    elem_last_i  = 1'b0;
    if (stim.size() > 0 && (!v_rand || $urandom_range(0, 1) == 1)) begin
      elem_valid_i = 1'b1;
      elem_data_i  = stim[0].d;
      elem_last_i  = stim[0].l;
    end
    m_axis_ready_i = (m_mode == 1) || (m_mode == 2 && $urandom_range(0, 1) == 1);
    acc = elem_valid_i && (exp_q.size() < DEPTH);
    pop = (exp_q.size() != 0) && m_axis_ready_i;
    if (pop) begin
      b = exp_q.pop_front();
      n_beats++;
      $display("beat %0d data=%08h last=%0b", n_beats, b[2*DW-1:0], b[2*DW]);
    end
    if (acc) begin
      e = stim.pop_front();
      model_accept(e.d, e.l);
    end
  endtask

  task automatic step();
    @(negedge axi_clock_i);
    check_outputs();
    drive();
  endtask

  task automatic push_elem(input logic [DW-1:0] d, input logic l);
    elem_t e;
    e.d = d;
    e.l = l;
    stim.push_back(e);
  endtask

  task automatic add_rand_vec(input int len);
    for (int i = 0; i < len; i++) push_elem(DW'($urandom), i == len - 1);
  endtask

  task automatic drain(input int limit);
    for (int c = 0; c < limit && (stim.size() != 0 || exp_q.size() != 0); c++) step();
    check_eq("drain_left", 64'(stim.size() + exp_q.size()), 64'd0);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_reset_n_i  = 1'b0;
    elem_valid_i   = 1'b0;
    elem_data_i    = '0;
    elem_last_i    = 1'b0;
    m_axis_ready_i = 1'b0;
    m_mode = 1;
    v_rand = 1'b0;
    model_reset();
    repeat (3) @(posedge axi_clock_i);
    @(negedge axi_clock_i);
    axi_reset_n_i = 1'b1;

    // Length 4, sequential values, always ready.
    for (int i = 1; i <= 4; i++) push_elem(DW'(i), i == 4);
    drain(50);

    // Length 3: odd tail is padded.
    push_elem(16'h0A00, 1'b0);
    push_elem(16'h0B00, 1'b0);
    push_elem(16'h0C00, 1'b1);
    drain(50);

    // Stall downstream: only four beats fit, then release.
    m_mode = 0;
    for (int i = 1; i <= 10; i++) push_elem(DW'(i), i == 10);
    repeat (20) step();
    m_mode = 1;
    drain(50);

    // Back-to-back lengths 5 and 6 with random downstream ready.
    m_mode = 2;
    add_rand_vec(5);
    add_rand_vec(6);
    drain(200);

    // 256-element vector saturates the length and sets overflow.
    m_mode = 1;
    add_rand_vec(256);
    drain(600);

    // Reset while holding a low half with two beats queued.
    m_mode = 0;
    for (int i = 0; i < 5; i++) push_elem(DW'(16'h1000 + i), 1'b0);
    repeat (8) step();
    @(negedge axi_clock_i);
    axi_reset_n_i  = 1'b0;
    elem_valid_i   = 1'b0;
    m_axis_ready_i = 1'b0;
    model_reset();
    @(negedge axi_clock_i);
    check_outputs();
    axi_reset_n_i = 1'b1;
    m_mode = 1;
    push_elem(16'h1234, 1'b0);
    push_elem(16'h5678, 1'b1);
    drain(50);

    // Random vectors, random valid and ready.
    m_mode = 2;
    v_rand = 1'b1;
    for (int v = 0; v < 20; v++) add_rand_vec($urandom_range(1, 12));
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
